// File: rtl/openhw_ram2p_req_ctrl.sv
// Requester for a 1R1W byte-enable two-port SRAM: zero-fills the array after reset, then turns the valid/ready read and write channels into SRAM strobes.
// Define RAM2P_WR_BYPASS_EN to accept colliding read/write pairs and forward the write data into the read response.
module openhw_ram2p_req_ctrl #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 68,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = (WIDTH - 1) / 8 + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             InitDone,
  input  logic             RdReqValid,
  input  logic [AW-1:0]    RdReqAdr,
  output logic             RdReqReady,
  output logic             RdRespValid,
  output logic [WIDTH-1:0] RdRespData,
  input  logic             WrReqValid,
  input  logic [AW-1:0]    WrReqAdr,
  input  logic [WIDTH-1:0] WrReqData,
  input  logic [BW-1:0]    WrReqByteEn,
  output logic             WrReqReady,
  output logic             ce1,
  output logic [AW-1:0]    ra1,
  input  logic [WIDTH-1:0] rd1,
  output logic             ce2,
  output logic             we2,
  output logic [AW-1:0]    wa2,
  output logic [WIDTH-1:0] wd2,
  output logic [BW-1:0]    bwe2
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt;
  logic          collision;
  logic          rd_fire;
  logic          wr_fire;

  assign collision = RdReqValid & WrReqValid & (RdReqAdr == WrReqAdr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_cnt == LAST_ADR) state_next = RUN;
  end

  // InitDone trails entry to RUN by one cycle; requests are only taken once it is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt     <= '0;
      InitDone    <= 1'b0;
      RdRespValid <= 1'b0;
    end else begin
      if (state == CLEAR && clr_cnt != LAST_ADR) clr_cnt <= clr_cnt + AW'(1);
      InitDone    <= (state == RUN);
      RdRespValid <= rd_fire;
    end
  end

  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    RdReqReady = 1'b0;
    WrReqReady = 1'b0;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    ce1        = 1'b0;
    ra1        = RdReqAdr;
    ce2        = 1'b0;
    we2        = 1'b0;
    wa2        = WrReqAdr;
    wd2        = WrReqData;
    bwe2       = WrReqByteEn;
    if (state == CLEAR) begin
      // NOTE: the SRAM array has no reset of its own, so it is zero-filled one word per cycle instead.
      ce2  = 1'b1;
      we2  = 1'b1;
      wa2  = clr_cnt;
      wd2  = '0;
      bwe2 = '1;
    end else if (InitDone) begin
      RdReqReady = 1'b1;
`ifdef RAM2P_WR_BYPASS_EN
      WrReqReady = 1'b1;
`else
      WrReqReady = ~collision;
`endif
      rd_fire = RdReqValid;
      wr_fire = WrReqValid & WrReqReady;
      ce1     = rd_fire;
      ce2     = wr_fire;
      we2     = wr_fire;
    end
  end

`ifdef RAM2P_WR_BYPASS_EN
  logic             byp_hit;
  logic [WIDTH-1:0] byp_data;
  logic [BW-1:0]    byp_be;
  logic [WIDTH-1:0] byp_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
      byp_be   <= '0;
    end else begin
      byp_hit  <= rd_fire & wr_fire & collision;
      byp_data <= WrReqData;
      byp_be   <= WrReqByteEn;
    end
  end

  // Expand lane enables to bit granularity; the partial top lane falls out naturally.
  always_comb begin
    byp_mask = '0;
    for (int b = 0; b < WIDTH; b++) byp_mask[b] = byp_hit & byp_be[b / 8];
  end

  assign RdRespData = (byp_data & byp_mask) | (rd1 & ~byp_mask);
`else
  assign RdRespData = rd1;
`endif

endmodule

// File: tb/tb_openhw_ram2p_req_ctrl.sv
// Directed bench for openhw_ram2p_req_ctrl with a behavioural 1R1W byte-enable SRAM attached.
module tb_openhw_ram2p_req_ctrl;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 68;
  localparam int AW    = 10;
  localparam int BW    = 9;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             InitDone;
  logic             RdReqValid;
  logic [AW-1:0]    RdReqAdr;
  logic             RdReqReady;
  logic             RdRespValid;
  logic [WIDTH-1:0] RdRespData;
  logic             WrReqValid;
  logic [AW-1:0]    WrReqAdr;
  logic [WIDTH-1:0] WrReqData;
  logic [BW-1:0]    WrReqByteEn;
  logic             WrReqReady;
  logic             ce1;
  logic [AW-1:0]    ra1;
  logic [WIDTH-1:0] rd1;
  logic             ce2;
  logic             we2;
  logic [AW-1:0]    wa2;
  logic [WIDTH-1:0] wd2;
  logic [BW-1:0]    bwe2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  openhw_ram2p_req_ctrl dut (
    .clk(clk), .reset_n(reset_n), .InitDone(InitDone),
    .RdReqValid(RdReqValid), .RdReqAdr(RdReqAdr), .RdReqReady(RdReqReady),
    .RdRespValid(RdRespValid), .RdRespData(RdRespData),
    .WrReqValid(WrReqValid), .WrReqAdr(WrReqAdr), .WrReqData(WrReqData),
    .WrReqByteEn(WrReqByteEn), .WrReqReady(WrReqReady),
    .ce1(ce1), .ra1(ra1), .rd1(rd1),
    .ce2(ce2), .we2(we2), .wa2(wa2), .wd2(wd2), .bwe2(bwe2)
  );

  // Behavioural SRAM: synchronous read-first port 1, byte-masked write port 2.
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom};
    rd1 = '0;
  end

  always @(posedge clk) begin
    if (ce1) rd1 <= mem[ra1];
    if (ce2 && we2)
      for (int b = 0; b < WIDTH; b++)
        if (bwe2[b / 8]) mem[wa2][b] <= wd2[b];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from reset release to InitDone and audits every clear write.
  task automatic run_clear(input string tag);
    int cycles = 0;
    int writes = 0;
    int bad    = 0;
    while (!InitDone && cycles < 2000) begin
      if (ce2 && we2) begin
        if (wa2 !== AW'(writes) || wd2 !== '0 || bwe2 !== 9'h1FF) bad++;
        writes++;
      end
      if (RdReqReady || WrReqReady) bad++;
      tick();
      cycles++;
    end
    check({tag, "_init_cycles"}, cycles, 1025);
    check({tag, "_clear_writes"}, writes, 1024);
    check({tag, "_clear_bad"}, bad, 0);
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] adr,
                          input logic [WIDTH-1:0] data, input logic [BW-1:0] be);
    WrReqValid = 1'b1; WrReqAdr = adr; WrReqData = data; WrReqByteEn = be;
    #1;
    check({tag, "_wr_ready"}, {WrReqReady, ce2, we2}, 3'b111);
    tick();
    WrReqValid = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] adr, input logic [WIDTH-1:0] exp);
    RdReqValid = 1'b1; RdReqAdr = adr;
    #1;
    check({tag, "_rd_strobe"}, {RdReqReady, ce1, 54'(ra1)}, {1'b1, 1'b1, 54'(adr)});
    tick();
    RdReqValid = 1'b0;
    check({tag, "_resp_valid"}, RdRespValid, 1'b1);
    check({tag, "_resp_data"}, RdRespData, exp);
  endtask

  function automatic logic [WIDTH-1:0] expected_word(input int adr);
    case (adr)
      3:       return 68'hA_5555_AAAA_1234_5678;
      7:       return 68'hF_FFFF_FFFF_FFFF_FF00;
      9:       return 68'h1;
      default: return '0;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    RdReqValid = 1'b0; RdReqAdr = '0;
    WrReqValid = 1'b0; WrReqAdr = '0; WrReqData = '0; WrReqByteEn = '0;
    repeat (3) tick();
    check("reset_outputs", {InitDone, RdRespValid, RdReqReady, WrReqReady, ce1}, 5'b0);

    // Zero-fill after reset, then a cleared word reads back as zero.
    reset_n = 1'b1;
    run_clear("t1");
    do_read("t1_adr5", 10'd5, '0);
    tick();
    check("t1_no_resp_idle", RdRespValid, 1'b0);

    // Full-width write then read-back.
    do_write("t2", 10'd3, 68'hA_5555_AAAA_1234_5678, 9'h1FF);
    do_read("t2_adr3", 10'd3, 68'hA_5555_AAAA_1234_5678);

    // Single-lane write into an all-ones word.
    do_write("t3_ones", 10'd7, '1, 9'h1FF);
    do_write("t3_lane0", 10'd7, '0, 9'h001);
    do_read("t3_adr7", 10'd7, 68'hF_FFFF_FFFF_FFFF_FF00);

    // Same-address read and write in one cycle.
    RdReqValid = 1'b1; RdReqAdr = 10'd9;
    WrReqValid = 1'b1; WrReqAdr = 10'd9; WrReqData = 68'h1; WrReqByteEn = 9'h1FF;
    #1;
`ifdef RAM2P_WR_BYPASS_EN
    check("t4_collide_ready", {RdReqReady, WrReqReady, ce2}, 3'b111);
    tick();
    RdReqValid = 1'b0; WrReqValid = 1'b0;
    check("t4_resp_valid", RdRespValid, 1'b1);
    check("t4_resp_bypass", RdRespData, 68'h1);
`else
    check("t4_collide_ready", {RdReqReady, WrReqReady, ce2}, 3'b100);
    tick();
    RdReqValid = 1'b0;
    check("t4_resp_valid", RdRespValid, 1'b1);
    check("t4_resp_old", RdRespData, 68'h0);
    #1;
    check("t4_retry_ready", {WrReqReady, ce2, 54'(wa2)}, {1'b1, 1'b1, 54'd9});
    tick();
    WrReqValid = 1'b0;
    check("t4_resp_unaltered", RdRespData, 68'h0);
`endif
    do_read("t4_adr9", 10'd9, 68'h1);

    // Streaming reads with concurrent writes to other addresses.
    begin
      int resp_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        RdReqValid = 1'b1; RdReqAdr = AW'(i);
        WrReqValid = 1'b1; WrReqAdr = AW'(16 + i);
        WrReqData = {36'h0, 32'hC0DE_0000 | 32'(i)}; WrReqByteEn = 9'h1FF;
        #1;
        check($sformatf("t6_ready_%0d", i), {RdReqReady, WrReqReady, ce1, ce2}, 4'b1111);
        tick();
        if (RdRespValid) resp_cnt++;
        check($sformatf("t6_data_%0d", i), RdRespData, expected_word(i));
      end
      RdReqValid = 1'b0; WrReqValid = 1'b0;
      check("t6_resp_count", resp_cnt, 16);
    end
    do_read("t6_adr20", 10'd20, 68'h0_0000_0000_C0DE_0004);

    // Reset during the clear at ClrCnt=500, then the fill restarts from 0.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (500) tick();
    check("t5_clrcnt500", {ce2, 54'(wa2)}, {1'b1, 54'd500});
    reset_n = 1'b0;
    #1;
    check("t5_clear_reset", {InitDone, 54'(wa2)}, 55'd0);
    tick();
    reset_n = 1'b1;
    run_clear("t5a");

    // Reset in RUN with a response pending.
    RdReqValid = 1'b1; RdReqAdr = 10'd3;
    tick();
    RdReqValid = 1'b0;
    check("t5_resp_pending", RdRespValid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t5_run_reset", {RdRespValid, InitDone, RdReqReady}, 3'b000);
    tick();
    reset_n = 1'b1;
    run_clear("t5b");
    do_read("t5_adr3_cleared", 10'd3, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
